// File: rtl/uart_imem_loader_if.sv
// Bus bundle between the UART image loader, the RX pin and the instruction-memory write port.
// The master side is the loader; the slave side is the memory/top-level glue that drives RX.
interface uart_imem_loader_if;
  logic        RX;
  logic        IMEM_WE;
  logic [31:0] IMEM_A;
  logic [31:0] IMEM_WD;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic        CORE_RST_N;

  modport master (
    input  RX,
    output IMEM_WE, IMEM_A, IMEM_WD, BUSY, DONE, ERR, CORE_RST_N
  );

  modport slave (
    output RX,
    input  IMEM_WE, IMEM_A, IMEM_WD, BUSY, DONE, ERR, CORE_RST_N
  );
endinterface

// File: rtl/uart_imem_loader.sv
// UART program-image loader: frame 0xA5, N, 4*N bytes -> N little-endian words written to imem.
// Define LOADER_CHECKSUM_EN to require a trailing XOR-of-all-data-bytes checksum byte.
//
// state   | meaning
// IDLE    | waiting for 0xA5 sync byte, other bytes dropped
// LEN     | expecting word count N (1..MAX_WORDS)
// DATA    | collecting four bytes of the current word
// WRITE   | one-cycle imem write strobe, advance word index
// CSUM    | expecting checksum byte (LOADER_CHECKSUM_EN only)
// FAIL    | load aborted, ERR raised, back to IDLE
module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int MAX_WORDS    = 14
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  uart_imem_loader_if.master        bus
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0]       MAX_LEN  = 9'(MAX_WORDS);

  localparam logic [1:0] B_IDLE  = 2'd0;
  localparam logic [1:0] B_START = 2'd1;
  localparam logic [1:0] B_DATA  = 2'd2;
  localparam logic [1:0] B_STOP  = 2'd3;

  localparam logic [2:0] F_IDLE  = 3'd0;
  localparam logic [2:0] F_LEN   = 3'd1;
  localparam logic [2:0] F_DATA  = 3'd2;
  localparam logic [2:0] F_WRITE = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] F_CSUM  = 3'd4;
`endif
  localparam logic [2:0] F_FAIL  = 3'd5;

  // ---------------- RX synchronizer ----------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------- bit engine ----------------
  logic [1:0]       bstate_q, bstate_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [2:0]       bidx_q, bidx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_vld;
  logic             frame_err;

  always_comb begin
    bstate_d  = bstate_q;
    bcnt_d    = bcnt_q;
    bidx_d    = bidx_q;
    shreg_d   = shreg_q;
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    if (bstate_q != B_IDLE && bcnt_q != '0) bcnt_d = bcnt_q - 1'b1;
    case (bstate_q)
      B_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          bstate_d = B_START;
          bcnt_d   = CNT_HALF;
        end
      end
      B_START: begin
        if (bcnt_q == '0) begin
          if (rx_sync_q) begin
            bstate_d = B_IDLE;
          end else begin
            bstate_d = B_DATA;
            bcnt_d   = CNT_FULL;
            bidx_d   = '0;
          end
        end
      end
      B_DATA: begin
        if (bcnt_q == '0) begin
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          bcnt_d  = CNT_FULL;
          bidx_d  = bidx_q + 3'd1;
          if (bidx_q == 3'd7) bstate_d = B_STOP;
        end
      end
      B_STOP: begin
        if (bcnt_q == '0) begin
          bstate_d = B_IDLE;
          if (rx_sync_q) byte_vld  = 1'b1;
          else           frame_err = 1'b1;
        end
      end
      default: bstate_d = B_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bstate_q <= B_IDLE;
      bcnt_q   <= '0;
      bidx_q   <= '0;
      shreg_q  <= '0;
    end else begin
      bstate_q <= bstate_d;
      bcnt_q   <= bcnt_d;
      bidx_q   <= bidx_d;
      shreg_q  <= shreg_d;
    end
  end

  // ---------------- frame FSM ----------------
  logic [2:0]  fstate_q, fstate_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  bytes_q, bytes_d;
  logic [23:0] word_q, word_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        boot_q;
  logic        go_fail, go_done;
  logic [7:0]  rx_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign rx_byte = shreg_q;

  always_comb begin
    fstate_d     = fstate_q;
    len_d        = len_q;
    idx_d        = idx_q;
    bytes_d      = bytes_q;
    word_d       = word_q;
    last_d       = last_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wd_d         = wd_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    core_rst_n_d = core_rst_n_q;
    go_fail      = 1'b0;
    go_done      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    // Out of reset the core is released to run whatever image is resident.
    if (!boot_q) core_rst_n_d = 1'b1;

    case (fstate_q)
      F_IDLE: begin
        if (byte_vld && rx_byte == 8'hA5) begin
          fstate_d     = F_LEN;
          busy_d       = 1'b1;
          core_rst_n_d = 1'b0;
          done_d       = 1'b0;
          err_d        = 1'b0;
          idx_d        = '0;
          bytes_d      = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d       = '0;
`endif
        end
      end
      F_LEN: begin
        if (frame_err) begin
          go_fail = 1'b1;
        end else if (byte_vld) begin
          if (rx_byte == 8'h00 || {1'b0, rx_byte} > MAX_LEN) begin
            go_fail = 1'b1;
          end else begin
            len_d    = rx_byte;
            fstate_d = F_DATA;
          end
        end
      end
      F_DATA: begin
        if (frame_err) begin
          go_fail = 1'b1;
        end else if (byte_vld) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_byte;
`endif
          if (bytes_q == 2'd3) begin
            bytes_d  = '0;
            we_d     = 1'b1;
            addr_d   = 32'({idx_q, 2'b00});
            wd_d     = {rx_byte, word_q};
            fstate_d = F_WRITE;
            last_d   = (idx_q + 8'd1 == len_q);
`ifndef LOADER_CHECKSUM_EN
            // Status flips together with the final strobe.
            go_done  = (idx_q + 8'd1 == len_q);
`endif
          end else begin
            bytes_d = bytes_q + 2'd1;
            word_d  = {rx_byte, word_q[23:8]};
          end
        end
      end
      F_WRITE: begin
        idx_d = idx_q + 8'd1;
        if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
          fstate_d = F_CSUM;
`else
          fstate_d = F_IDLE;
`endif
        end else begin
          fstate_d = F_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      F_CSUM: begin
        if (frame_err) begin
          go_fail = 1'b1;
        end else if (byte_vld) begin
          if (rx_byte == csum_q) begin
            go_done  = 1'b1;
            fstate_d = F_IDLE;
          end else begin
            go_fail = 1'b1;
          end
        end
      end
`endif
      F_FAIL: fstate_d = F_IDLE;
      default: fstate_d = F_IDLE;
    endcase

    if (go_fail) begin
      fstate_d = F_FAIL;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b1;
    end
    if (go_done) begin
      busy_d       = 1'b0;
      done_d       = 1'b1;
      core_rst_n_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fstate_q     <= F_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      bytes_q      <= '0;
      word_q       <= '0;
      last_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wd_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
      boot_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      fstate_q     <= fstate_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      bytes_q      <= bytes_d;
      word_q       <= word_d;
      last_q       <= last_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_rst_n_q <= core_rst_n_d;
      boot_q       <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.IMEM_WE    = we_q;
  assign bus.IMEM_A     = addr_q;
  assign bus.IMEM_WD    = wd_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.ERR        = err_q;
  assign bus.CORE_RST_N = core_rst_n_q;

endmodule
